popcount_accumulator: RTL and testbench

Streaming bit-count accumulator. It accepts a stream of bitmask words over a valid/ready handshake and computes the population count of each word in a registered stage. It sums those counts over a frame delimited by `input_last`, then presents the frame total, word count and overflow flag on an output valid/ready handshake. It sits directly downstream of the combinational population-count function, which it uses internally, and turns per-word counts into per-frame statistics, for example for occupancy, error-weight or density measurement.

---
 rtl/popcount_accumulator.sv | 130 +++++++++++++
 tb/tb_popcount_accumulator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_accumulator.sv
// Streaming popcount accumulator: counts set bits per word in a registered stage,
// sums them over a frame ended by input_last and hands out saturated frame statistics.
module popcount_accumulator #(
    parameter int WORD_WIDTH  = 32,
    parameter int TOTAL_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_data,
    input  logic                   input_last,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [TOTAL_WIDTH-1:0] output_total,
    output logic [TOTAL_WIDTH-1:0] output_words,
    output logic                   output_overflow
);

    localparam int COUNT_WIDTH = $clog2(WORD_WIDTH) + 1;
    localparam int SUM_WIDTH   = TOTAL_WIDTH + 1;

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    state_t                 state;

    logic                   count_valid;
    logic [COUNT_WIDTH-1:0] count_value;
    logic                   count_last;

    logic [TOTAL_WIDTH-1:0] acc_total;
    logic [TOTAL_WIDTH-1:0] acc_words;
    logic                   acc_overflow;

    logic                   accept;
    logic [COUNT_WIDTH-1:0] word_ones;
    logic [SUM_WIDTH-1:0]   total_sum;
    logic [SUM_WIDTH-1:0]   words_sum;
    logic [TOTAL_WIDTH-1:0] total_next;
    logic [TOTAL_WIDTH-1:0] words_next;
    logic                   overflow_next;

    function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [WORD_WIDTH-1:0] word);
        logic [COUNT_WIDTH-1:0] ones;
        ones = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            ones = ones + COUNT_WIDTH'(word[i]);
        end
        return ones;
    endfunction

    // The count stage may refill while DONE waits, but only if it is empty.
    assign input_ready = (state == ACCUM) || !count_valid;
    assign accept      = input_valid && input_ready;
    assign word_ones   = popcount(input_data);

    // One extra bit catches the carry; a carry pins the field at all-ones.
    always_comb begin
        total_sum     = {1'b0, acc_total} + SUM_WIDTH'(count_value);
        words_sum     = {1'b0, acc_words} + SUM_WIDTH'(1);
        total_next    = total_sum[TOTAL_WIDTH] ? '1 : total_sum[TOTAL_WIDTH-1:0];
        words_next    = words_sum[TOTAL_WIDTH] ? '1 : words_sum[TOTAL_WIDTH-1:0];
        overflow_next = acc_overflow || total_sum[TOTAL_WIDTH] || words_sum[TOTAL_WIDTH];
    end

    // NOTE: registers use non-blocking assignments so every always_ff reads the
    // pre-edge value of every other register, independent of block ordering.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            count_valid <= 1'b0;
            count_value <= '0;
            count_last  <= 1'b0;
        end else if (accept) begin
            count_valid <= 1'b1;
            count_value <= word_ones;
            count_last  <= input_last;
        end else if (state == ACCUM) begin
            count_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state           <= ACCUM;
            acc_total       <= '0;
            acc_words       <= '0;
            acc_overflow    <= 1'b0;
            output_valid    <= 1'b0;
            output_total    <= '0;
            output_words    <= '0;
            output_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (count_valid) begin
                        acc_total    <= total_next;
                        acc_words    <= words_next;
                        acc_overflow <= overflow_next;
                        if (count_last) begin
                            output_total    <= total_next;
                            output_words    <= words_next;
                            output_overflow <= overflow_next;
                            output_valid    <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (output_ready) begin
                        acc_total    <= '0;
                        acc_words    <= '0;
                        acc_overflow <= 1'b0;
                        output_valid <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // A presented result must not change or vanish until it is taken.
    assert property (@(posedge clock) disable iff (!clear_n)
        output_valid && !output_ready |=> output_valid && $stable(output_total)
            && $stable(output_words) && $stable(output_overflow));

endmodule

// File: tb/tb_popcount_accumulator.sv
// Self-checking bench for popcount_accumulator: table-driven frames, hand-written
// corner sequences and a randomized run against a frame-level reference model.
module tb_popcount_accumulator;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       output_valid;
    logic       output_ready;
    logic [5:0] output_total;
    logic [5:0] output_words;
    logic       output_overflow;

    logic       v7;
    logic       r7;
    logic [6:0] d7;
    logic       l7;
    logic       ov7;
    logic       or7;
    logic [5:0] tot7;
    logic [5:0] wds7;
    logic       ovf7;

    always #5 clock = ~clock;

    popcount_accumulator #(.WORD_WIDTH(8), .TOTAL_WIDTH(6)) dut8 (
        .clock(clock), .clear_n(clear_n),
        .input_valid(in_valid), .input_ready(in_ready),
        .input_data(in_data), .input_last(in_last),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_total(output_total), .output_words(output_words),
        .output_overflow(output_overflow)
    );

    popcount_accumulator #(.WORD_WIDTH(7), .TOTAL_WIDTH(6)) dut7 (
        .clock(clock), .clear_n(clear_n),
        .input_valid(v7), .input_ready(r7),
        .input_data(d7), .input_last(l7),
        .output_valid(ov7), .output_ready(or7),
        .output_total(tot7), .output_words(wds7),
        .output_overflow(ovf7)
    );

    typedef struct packed {
        logic [5:0] tot;
        logic [5:0] wds;
        logic       ovf;
    } result_t;

    typedef struct packed {
        logic [3:0]      n;
        logic [7:0][7:0] w;
        result_t         exp;
    } frame_t;

    int      checks = 0;
    int      fails  = 0;
    result_t got_q[$];
    result_t exp_q[$];
    frame_t  tbl[5];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Results are captured on the falling edge before the handshake edge.
    logic    hold_prev = 1'b0;
    result_t held;
    result_t cur;
    always @(negedge clock) begin
        cur = {output_total, output_words, output_overflow};
        if (hold_prev) check("hold", {31'd0, output_valid} << 13 | 32'(cur), (32'd1 << 13) | 32'(held));
        if (output_valid && output_ready && clear_n) got_q.push_back(cur);
        hold_prev = output_valid && !output_ready && clear_n;
        held      = cur;
    end

    task automatic send_word(input logic [7:0] d, input logic l, output int stalls);
        bit done;
        done     = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 100 && !done; t++) begin
            if (in_ready) done = 1'b1;
            else stalls++;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_word: input_ready never rose, got timeout, expected acceptance");
        end
    endtask

    task automatic expect_result(input string name, input result_t exp);
        result_t r;
        int      t;
        t = 0;
        while (got_q.size() == 0 && t < 300) begin
            step();
            t++;
        end
        if (got_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: got no result, expected total=%0d words=%0d", name, exp.tot, exp.wds);
        end else begin
            r = got_q.pop_front();
            check({name, " total"}, 32'(r.tot), 32'(exp.tot));
            check({name, " words"}, 32'(r.wds), 32'(exp.wds));
            check({name, " ovf"}, 32'(r.ovf), 32'(exp.ovf));
        end
    endtask

    int      st;
    int      stall_sum;
    int      r_sum;
    int      r_n;
    logic [7:0] r_d;
    result_t r_exp;
    bit      rand_done;

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; output_ready = 1'b1;
        v7 = 1'b0; d7 = '0; l7 = 1'b0; or7 = 1'b1;
        rand_done = 1'b0;

        // Frame table: word lists and hand-computed results.
        tbl[0] = '0; tbl[0].n = 3; tbl[0].w[0] = 8'h01; tbl[0].w[1] = 8'h03; tbl[0].w[2] = 8'h07;
        tbl[0].exp = '{tot: 6'd6, wds: 6'd3, ovf: 1'b0};
        tbl[1] = '0; tbl[1].n = 8;
        for (int i = 0; i < 8; i++) tbl[1].w[i] = 8'hFF;
        tbl[1].exp = '{tot: 6'd63, wds: 6'd8, ovf: 1'b1};
        tbl[2] = '0; tbl[2].n = 1; tbl[2].w[0] = 8'h0F;
        tbl[2].exp = '{tot: 6'd4, wds: 6'd1, ovf: 1'b0};
        tbl[3] = '0; tbl[3].n = 2; tbl[3].w[0] = 8'hAA; tbl[3].w[1] = 8'h55;
        tbl[3].exp = '{tot: 6'd8, wds: 6'd2, ovf: 1'b0};
        tbl[4] = '0; tbl[4].n = 1; tbl[4].w[0] = 8'h00;
        tbl[4].exp = '{tot: 6'd0, wds: 6'd1, ovf: 1'b0};

        step(); step();
        clear_n = 1'b1;
        check("rst valid", 32'(output_valid), 32'd0);
        check("rst total", 32'(output_total), 32'd0);
        check("rst words", 32'(output_words), 32'd0);
        check("rst ovf", 32'(output_overflow), 32'd0);
        check("rst ready", 32'(in_ready), 32'd1);

        // Single-word frame: valid appears one edge after the consuming edge, for one cycle.
        send_word(8'hFF, 1'b1, st);
        check("s1 valid early", 32'(output_valid), 32'd0);
        step();
        check("s1 valid", 32'(output_valid), 32'd1);
        step();
        check("s1 valid drop", 32'(output_valid), 32'd0);
        expect_result("s1", '{tot: 6'd8, wds: 6'd1, ovf: 1'b0});

        foreach (tbl[f]) begin
            stall_sum = 0;
            for (int i = 0; i < int'(tbl[f].n); i++) begin
                send_word(tbl[f].w[i], i == int'(tbl[f].n) - 1, st);
                stall_sum += st;
            end
            check($sformatf("tbl%0d stalls", f), 32'(stall_sum), 32'd0);
            expect_result($sformatf("tbl%0d", f), tbl[f].exp);
        end

        // Word-count saturation: 64 empty words in one frame.
        for (int i = 0; i < 64; i++) send_word(8'h00, i == 63, st);
        expect_result("wsat", '{tot: 6'd0, wds: 6'd63, ovf: 1'b1});

        // Backpressure: result A held while frame B stalls in the count stage.
        output_ready = 1'b0;
        send_word(8'hAA, 1'b1, st);
        send_word(8'h80, 1'b0, st);
        check("bp 80 stalls", 32'(st), 32'd0);
        check("bp ready low", 32'(in_ready), 32'd0);
        check("bp valid", 32'(output_valid), 32'd1);
        in_valid = 1'b1; in_data = 8'h81; in_last = 1'b1;
        repeat (3) step();
        check("bp ready still low", 32'(in_ready), 32'd0);
        check("bp A total", 32'(output_total), 32'd4);
        check("bp A words", 32'(output_words), 32'd1);
        output_ready = 1'b1;
        send_word(8'h81, 1'b1, st);
        check("bp 81 stalls", 32'(st), 32'd1);
        expect_result("bp A", '{tot: 6'd4, wds: 6'd1, ovf: 1'b0});
        expect_result("bp B", '{tot: 6'd3, wds: 6'd2, ovf: 1'b0});

        // Reset mid-frame discards the partial frame and the pending count.
        send_word(8'hFF, 1'b0, st);
        send_word(8'hFF, 1'b0, st);
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        check("mrst valid", 32'(output_valid), 32'd0);
        check("mrst ready", 32'(in_ready), 32'd1);
        check("mrst no result", 32'(got_q.size()), 32'd0);
        send_word(8'h01, 1'b1, st);
        expect_result("mrst", '{tot: 6'd1, wds: 6'd1, ovf: 1'b0});
        repeat (4) step();
        check("mrst extra result", 32'(got_q.size()), 32'd0);

        // Randomized frames with gaps and random output backpressure.
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    r_n   = int'($urandom_range(1, 12));
                    r_sum = 0;
                    for (int i = 0; i < r_n; i++) begin
                        r_d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                        r_sum += $countones(r_d);
                        repeat ($urandom_range(0, 2)) step();
                        send_word(r_d, i == r_n - 1, st);
                    end
                    r_exp.tot = (r_sum > 63) ? 6'd63 : 6'(r_sum);
                    r_exp.wds = 6'(r_n);
                    r_exp.ovf = (r_sum > 63);
                    exp_q.push_back(r_exp);
                end
            end
            begin
                for (int f = 0; f < 40; f++) begin
                    int t;
                    t = 0;
                    while (exp_q.size() == 0 && t < 300) begin
                        step();
                        t++;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL rand%0d: got no frame sent, expected one", f);
                    end else begin
                        expect_result($sformatf("rand%0d", f), exp_q.pop_front());
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    output_ready = 1'($urandom_range(0, 1));
                    step();
                end
                output_ready = 1'b1;
            end
        join

        // Odd word width with an all-zero word.
        v7 = 1'b1; d7 = 7'h7F; l7 = 1'b0;
        check("w7 ready", 32'(r7), 32'd1);
        step();
        d7 = 7'h00; l7 = 1'b1;
        step();
        v7 = 1'b0;
        for (int t = 0; t < 10 && !ov7; t++) step();
        check("w7 valid", 32'(ov7), 32'd1);
        check("w7 total", 32'(tot7), 32'd7);
        check("w7 words", 32'(wds7), 32'd2);
        check("w7 ovf", 32'(ovf7), 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
